// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline hazard control.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    IWAIT,
    IWAIT_KILL
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Hazard classes; the resolution order is fixed in hazard_sequencer.
  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_IFETCH,
    HZ_LOADUSE,
    HZ_REDIRECT,
    HZ_DWAIT
  } hazard_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the 5-stage pipeline; tracks fetches that must be
// discarded because a redirect arrived while they were outstanding.
module hazard_sequencer
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             IMemReadyF,
  input  logic             DMemReqM,
  input  logic             DMemReadyM,
  output logic             StallF,
  output logic             StallD_HDU,
  output logic             FlushD_CHU,
  output logic             StallE,
  output logic             FlushE,
  output logic             StallM,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  state_e  state_q, state_d;
  hazard_e hz;
  logic    dwait, lu, iwait, flush_inc;

  always_comb begin
    dwait = DMemReqM & ~DMemReadyM;
    lu    = LoadE & (RdE != REG_X0) & ((RdE == Rs1D) | (RdE == Rs2D));
    iwait = ~IMemReadyF;

    if (dwait)                                           hz = HZ_DWAIT;
    else if (PCSrcE)                                     hz = HZ_REDIRECT;
    else if (lu)                                         hz = HZ_LOADUSE;
    else if (iwait || (state_q == IWAIT_KILL))           hz = HZ_IFETCH;
    else                                                 hz = HZ_NONE;
  end

  always_comb begin
    StallF     = 1'b0;
    StallD_HDU = 1'b0;
    FlushD_CHU = 1'b0;
    StallE     = 1'b0;
    FlushE     = 1'b0;
    StallM     = 1'b0;
    state_d    = state_q;

    unique case (hz)
      HZ_DWAIT: begin
        StallF     = 1'b1;
        StallD_HDU = 1'b1;
        StallE     = 1'b1;
        StallM     = 1'b1;
      end
      HZ_REDIRECT: begin
        FlushD_CHU = 1'b1;
        FlushE     = 1'b1;
      end
      HZ_LOADUSE: begin
        StallF     = 1'b1;
        StallD_HDU = 1'b1;
        FlushE     = 1'b1;
      end
      HZ_IFETCH: begin
        StallF     = 1'b1;
        FlushD_CHU = 1'b1;
      end
      default: ;
    endcase

    // Execute is frozen under a data wait, so fetch tracking is frozen with it.
    if (hz == HZ_REDIRECT) begin
      state_d = iwait ? IWAIT_KILL : RUN;
    end else if (hz != HZ_DWAIT) begin
      unique case (state_q)
        RUN:        if (iwait) state_d = IWAIT;
        IWAIT:      if (!iwait) state_d = RUN;
        IWAIT_KILL: if (!iwait) state_d = RUN;
        default:    state_d = RUN;
      endcase
    end

    if (reset) begin
      StallF     = 1'b0;
      StallD_HDU = 1'b0;
      FlushD_CHU = 1'b0;
      StallE     = 1'b0;
      FlushE     = 1'b0;
      StallM     = 1'b0;
    end

    flush_inc = (hz == HZ_REDIRECT) & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (FlushCnt)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer, with a narrow-counter
// instance alongside to exercise saturation.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        LoadE, PCSrcE, IMemReadyF, DMemReqM, DMemReadyM;
  logic        StallF, StallD_HDU, FlushD_CHU, StallE, FlushE, StallM;
  logic [15:0] StallCnt, FlushCnt;
  logic        s_StallF, s_StallD_HDU, s_FlushD_CHU, s_StallE, s_FlushE, s_StallM;
  logic [1:0]  s_StallCnt, s_FlushCnt;

  always #5 clk = ~clk;

  hazard_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .IMemReadyF(IMemReadyF),
    .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .StallF(StallF), .StallD_HDU(StallD_HDU), .FlushD_CHU(FlushD_CHU),
    .StallE(StallE), .FlushE(FlushE), .StallM(StallM),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  hazard_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .IMemReadyF(IMemReadyF),
    .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .StallF(s_StallF), .StallD_HDU(s_StallD_HDU), .FlushD_CHU(s_FlushD_CHU),
    .StallE(s_StallE), .FlushE(s_FlushE), .StallM(s_StallM),
    .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
  );

  typedef struct {
    string       tag;
    logic [5:0]  outs;   // {StallF, StallD, FlushD, StallE, FlushE, StallM}
    logic [15:0] sc;
    logic [15:0] fc;
    logic [1:0]  sc2;
    logic [1:0]  fc2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_n = 0;
  int   flush_n = 0;

  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_DW   = 6'b110101;
  localparam logic [5:0] O_RED  = 6'b001010;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_IF   = 6'b101000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic rst_v,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic ld, input logic pc, input logic irdy,
                      input logic dreq, input logic drdy, input logic [5:0] expo);
    exp_t e, got;
    @(negedge clk);
    reset = rst_v; Rs1D = rs1; Rs2D = rs2; RdE = rd; LoadE = ld; PCSrcE = pc;
    IMemReadyF = irdy; DMemReqM = dreq; DMemReadyM = drdy;
    if (rst_v) begin
      stall_n = 0;
      flush_n = 0;
    end
    e.tag  = tag;
    e.outs = expo;
    e.sc   = 16'(stall_n);
    e.fc   = 16'(flush_n);
    e.sc2  = 2'((stall_n > 3) ? 3 : stall_n);
    e.fc2  = 2'((flush_n > 3) ? 3 : flush_n);
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".outs"}, 16'({StallF, StallD_HDU, FlushD_CHU, StallE, FlushE, StallM}), 16'(got.outs));
    chk({got.tag, ".outs_n"}, 16'({s_StallF, s_StallD_HDU, s_FlushD_CHU, s_StallE, s_FlushE, s_StallM}), 16'(got.outs));
    chk({got.tag, ".StallCnt"}, StallCnt, got.sc);
    chk({got.tag, ".FlushCnt"}, FlushCnt, got.fc);
    chk({got.tag, ".StallCnt_sat"}, 16'(s_StallCnt), 16'(got.sc2));
    chk({got.tag, ".FlushCnt_sat"}, 16'(s_FlushCnt), 16'(got.fc2));
    chk({got.tag, ".d_excl"}, 16'(StallD_HDU & FlushD_CHU), 16'h0);
    if (!rst_v) begin
      if (expo[5]) stall_n++;
      if (expo[3] && expo[1]) flush_n++;
    end
  endtask

  initial begin
    reset = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0; LoadE = 1'b0; PCSrcE = 1'b0;
    IMemReadyF = 1'b1; DMemReqM = 1'b0; DMemReadyM = 1'b0;

    step("reset",    1, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    step("idle",     0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    // load-use on rs1, then the load leaves Execute
    step("lu_rs1",   0, 5, 1, 5, 1, 0, 1, 0, 0, O_LU);
    step("lu_done",  0, 5, 1, 7, 0, 0, 1, 0, 0, O_IDLE);
    step("lu_rs2",   0, 2, 9, 9, 1, 0, 1, 0, 0, O_LU);
    step("x0_load",  0, 3, 0, 0, 1, 0, 1, 0, 0, O_IDLE);
    step("lu_miss",  0, 3, 4, 6, 1, 0, 1, 0, 0, O_IDLE);
    // taken branch in RUN
    step("branch",   0, 0, 0, 0, 0, 1, 1, 0, 0, O_RED);
    step("br_after", 0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    // fetch miss with redirect while outstanding
    step("fm_c1",    0, 0, 0, 0, 0, 0, 0, 0, 0, O_IF);
    step("fm_c2",    0, 0, 0, 0, 0, 1, 0, 0, 0, O_RED);
    step("fm_c3",    0, 0, 0, 0, 0, 0, 0, 0, 0, O_IF);
    step("fm_c4",    0, 0, 0, 0, 0, 0, 1, 0, 0, O_IF);
    step("fm_run",   0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    // data wait freezes a pending branch
    step("dw_c1",    0, 0, 0, 0, 0, 1, 1, 1, 0, O_DW);
    step("dw_c2",    0, 0, 0, 0, 0, 1, 1, 1, 0, O_DW);
    step("dw_c3",    0, 0, 0, 0, 0, 1, 1, 1, 0, O_DW);
    step("dw_c4",    0, 0, 0, 0, 0, 1, 1, 1, 0, O_DW);
    step("dw_c5",    0, 0, 0, 0, 0, 1, 1, 1, 1, O_RED);
    step("dw_after", 0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    // data wait during fetch miss must not arm the kill on a branch
    step("dwf_c1",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_IF);
    step("dwf_c2",   0, 0, 0, 0, 0, 1, 0, 1, 0, O_DW);
    step("dwf_c3",   0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    // load-use coinciding with fetch miss
    step("luif_c1",  0, 8, 0, 8, 1, 0, 0, 0, 0, O_LU);
    step("luif_c2",  0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    // another redirect pushes the narrow flush counter past saturation
    step("branch2",  0, 0, 0, 0, 0, 1, 1, 0, 0, O_RED);
    step("br2_after",0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    // reset while in IWAIT_KILL
    step("rk_c1",    0, 0, 0, 0, 0, 0, 0, 0, 0, O_IF);
    step("rk_c2",    0, 0, 0, 0, 0, 1, 0, 0, 0, O_RED);
    step("rk_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
    step("rk_rst2",  1, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    step("rk_rel",   0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);
    step("rk_idle",  0, 0, 0, 0, 0, 0, 1, 0, 0, O_IDLE);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_residue observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Drives the hold and clear controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, taken-branch/jump redirects, multi-cycle instruction-memory fetch waits and data-memory waits.
- Tracks in a small FSM a redirect that arrives while a fetch is still outstanding, so the stale instruction is discarded when it returns.
- Sits beside the pipeline registers; no datapath passes through it.

Parameters:
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- Rs1D  in  5  rs1 of the instruction in Decode.
- Rs2D  in  5  rs2 of the instruction in Decode.
- RdE  in  5  rd of the instruction in Execute.
- LoadE  in  1  instruction in Execute is a load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- IMemReadyF  in  1  instruction memory returned valid data this cycle.
- DMemReqM  in  1  Memory stage has an active load or store.
- DMemReadyM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold the PC.
- StallD_HDU  out  1  hold the IF/ID register.
- FlushD_CHU  out  1  clear the IF/ID register (bubble).
- StallE  out  1  hold the ID/EX register.
- FlushE  out  1  clear the ID/EX register.
- StallM  out  1  hold the EX/MEM register.
- StallCnt  out  CNT_W  cycles with StallF=1, saturating.
- FlushCnt  out  CNT_W  redirect events, saturating.

Behaviour:
- State register encodings are RUN, IWAIT and IWAIT_KILL.
  - RUN: no fetch outstanding.
  - IWAIT: fetch outstanding, no redirect pending.
  - IWAIT_KILL: fetch outstanding, and its data must be discarded.
- Stall/flush outputs are combinational from the state register and current inputs, giving zero-cycle latency.
- Counters and state are registered.
- Reset (asynchronous):
  - State goes to RUN; StallCnt and FlushCnt go to 0.
  - While reset is high, all stall/flush outputs are forced to 0.
  - Reset asserted mid-wait abandons the pending kill.
- Helper signals:
  - dwait = DMemReqM & ~DMemReadyM
  - lu = LoadE & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D)
  - iwait = ~IMemReadyF
- Priority, highest first:
  1. dwait: StallF, StallD_HDU, StallE and StallM are all 1; both flushes are 0. PCSrcE is ignored this cycle because Execute is frozen, and it is re-evaluated after release. The state holds, except that IWAIT moves to IWAIT_KILL never under dwait.
  2. PCSrcE: FlushD_CHU=1 and FlushE=1; all stalls are 0. FlushCnt increments. If iwait, or if state≠RUN without IMemReadyF, the next state is IWAIT_KILL.
  3. lu: StallF=1, StallD_HDU=1, FlushE=1. This is exactly one bubble, because the load leaves Execute next cycle.
  4. iwait, or IMemReadyF in state IWAIT_KILL: StallF=1 and FlushD_CHU=1, i.e. a bubble into Decode. StallD_HDU must not also be 1.
  5. Otherwise all outputs are 0.
- Transitions:
  - RUN → IWAIT when iwait.
  - IWAIT → RUN on IMemReadyF.
  - IWAIT → IWAIT_KILL on PCSrcE with iwait.
  - IWAIT_KILL → RUN on IMemReadyF. The returning word is flushed and StallF=1 that cycle so the redirected PC is refetched.
- Simultaneous lu and iwait: the lu outputs apply, with StallF=1 and FlushD_CHU=0, and the FSM still tracks iwait.
- Invariant: StallD_HDU and FlushD_CHU are never both 1; an assertion checks this in the bench.
- Counters:
  - StallCnt increments every cycle StallF=1 and holds at 2^CNT_W-1.
  - FlushCnt increments each cycle PCSrcE is acted on (priority 2) and saturates the same way.
  - Neither counter wraps.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - the state enum (RUN/IWAIT/IWAIT_KILL);
  - the REG_X0 constant (5'd0);
  - the hazard-priority encoding constants.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice.

Test Plan:
- Load-use: LoadE=1, RdE=5, Rs1D=5, all memories ready → exactly one cycle of StallF=StallD_HDU=FlushE=1, then all outputs 0. StallCnt goes 0→1.
- x0 load: LoadE=1, RdE=0, Rs2D=0 → no stall, all outputs 0.
- Branch: PCSrcE=1 for 1 cycle in RUN → FlushD_CHU=FlushE=1 that cycle and no stall. FlushCnt=1.
- Fetch miss plus redirect: IMemReadyF=0 for 3 cycles with PCSrcE=1 in cycle 2, ready in cycle 4 → states go IWAIT→IWAIT_KILL→RUN, and in cycle 4 FlushD_CHU=1 and StallF=1.
- Data wait: DMemReqM=1, DMemReadyM=0 for 4 cycles while PCSrcE=1 → 4 cycles of all stalls=1 with flushes 0. Then in cycle 5 FlushD_CHU=FlushE=1.
- Reset mid-wait: assert reset in IWAIT_KILL → outputs go to 0 immediately and the counters read 0. After release with IMemReadyF=1, no spurious flush.
